// File: rtl/gpr_if.sv
// Register-file access bundle: read, write, reserve and bank-clear signals.
// The master modport drives requests, the slave (the register file) answers.
interface gpr_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BANK_W   = 1,
  parameter int RD_PORTS = 2
);
  logic [BANK_W-1:0]          bank_sel;
  logic [RD_PORTS*ADDR_W-1:0] rd_addr;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [RD_PORTS-1:0]        rd_busy;
  logic                       wr0_en;
  logic [ADDR_W-1:0]          wr0_addr;
  logic [DATA_W-1:0]          wr0_data;
  logic                       wr1_en;
  logic [ADDR_W-1:0]          wr1_addr;
  logic [DATA_W-1:0]          wr1_data;
  logic                       rsv_en;
  logic [ADDR_W-1:0]          rsv_addr;
  logic                       clr_req;
  logic [BANK_W-1:0]          clr_bank;
  logic                       clr_busy;
  logic                       clr_done;
  logic                       wr_drop;

  modport master (
    output bank_sel, rd_addr,
    output wr0_en, wr0_addr, wr0_data,
    output wr1_en, wr1_addr, wr1_data,
    output rsv_en, rsv_addr,
    output clr_req, clr_bank,
    input  rd_data, rd_busy,
    input  clr_busy, clr_done, wr_drop
  );

  modport slave (
    input  bank_sel, rd_addr,
    input  wr0_en, wr0_addr, wr0_data,
    input  wr1_en, wr1_addr, wr1_data,
    input  rsv_en, rsv_addr,
    input  clr_req, clr_bank,
    output rd_data, rd_busy,
    output clr_busy, clr_done, wr_drop
  );
endinterface

// File: rtl/gpr_banked.sv
// Banked GPR file: N bypassed read ports, two write ports, a per-register
// reservation scoreboard and a sequenced bank-clear engine.
module gpr_banked #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BANK_W   = 1,
  parameter int RD_PORTS = 2,
  parameter int ZERO_R0  = 0
) (
  input logic clk,
  input logic reset,
  gpr_if.slave bus
);
  localparam int REG_NUM = 1 << ADDR_W;
  localparam int BANKS   = 1 << BANK_W;
  localparam int ENTRIES = BANKS * REG_NUM;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t state, state_n;
  logic [BANK_W-1:0] cbank;
  logic [ADDR_W-1:0] ptr;

  logic [ENTRIES*DATA_W-1:0] words;
  logic [ENTRIES-1:0]        busys;

  logic drop, live0, live1, live_rsv;

  function automatic logic is_r0(input logic [ADDR_W-1:0] a);
    return (ZERO_R0 != 0) && (a == '0);
  endfunction

  assign drop     = (state == CLEAR) && (bus.bank_sel == cbank);
  assign live0    = bus.wr0_en && !drop && !is_r0(bus.wr0_addr);
  assign live1    = bus.wr1_en && !drop && !is_r0(bus.wr1_addr);
  assign live_rsv = bus.rsv_en && !drop && !is_r0(bus.rsv_addr);

  assign bus.wr_drop  = drop && (bus.wr0_en || bus.wr1_en);
  assign bus.clr_busy = (state == CLEAR);
  assign bus.clr_done = (state == DONE);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.clr_req) state_n = CLEAR;
      CLEAR:   if (ptr == ADDR_W'(REG_NUM - 1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cbank <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.clr_req) begin
        cbank <= bus.clr_bank;
        ptr   <= '0;
      end else if (state == CLEAR && state_n == CLEAR) begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    for (genvar r = 0; r < REG_NUM; r++) begin : g_reg
      localparam int I = b * REG_NUM + r;
      logic [DATA_W-1:0] q;
      logic busy, sel, hit0, hit1, hitr, wipe;

      assign sel  = (bus.bank_sel == BANK_W'(b));
      assign hit0 = live0 && sel && (bus.wr0_addr == ADDR_W'(r));
      assign hit1 = live1 && sel && (bus.wr1_addr == ADDR_W'(r));
      assign hitr = live_rsv && sel && (bus.rsv_addr == ADDR_W'(r));
      assign wipe = (state == CLEAR) && (cbank == BANK_W'(b))
                    && (ptr == ADDR_W'(r));

      // a same-cycle reserve wins over the write's release of the bit
      always_ff @(posedge clk) begin
        if (reset) begin
          q    <= '0;
          busy <= 1'b0;
        end else begin
          if (wipe)      q <= '0;
          else if (hit1) q <= bus.wr1_data;
          else if (hit0) q <= bus.wr0_data;
          if (wipe)              busy <= 1'b0;
          else if (hitr)         busy <= 1'b1;
          else if (hit0 || hit1) busy <= 1'b0;
        end
      end

      assign words[I*DATA_W +: DATA_W] = q;
      assign busys[I] = busy;
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0]        a;
    logic [BANK_W+ADDR_W-1:0] idx;
    logic                     byp0, byp1;

    assign a    = bus.rd_addr[p*ADDR_W +: ADDR_W];
    assign idx  = {bus.bank_sel, a};
    assign byp1 = live1 && (bus.wr1_addr == a);
    assign byp0 = live0 && (bus.wr0_addr == a);

    assign bus.rd_data[p*DATA_W +: DATA_W] =
      is_r0(a) ? '0 :
      byp1     ? bus.wr1_data :
      byp0     ? bus.wr0_data :
                 words[idx*DATA_W +: DATA_W];
    assign bus.rd_busy[p] = busys[idx] && !byp0 && !byp1;
  end
endmodule

// File: tb/tb_gpr_banked.sv
// Bench for gpr_banked: model-backed scoreboard of read data, busy bits
// and clear-engine status, with ZERO_R0 enabled.
module tb_gpr_banked;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int BW = 1;
  localparam int RP = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gpr_if #(.DATA_W(DW), .ADDR_W(AW), .BANK_W(BW), .RD_PORTS(RP)) bus ();

  gpr_banked #(
    .DATA_W(DW), .ADDR_W(AW), .BANK_W(BW), .RD_PORTS(RP), .ZERO_R0(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mm[2][32];
  bit          mb[2][32];

  task automatic idle();
    bus.bank_sel = '0;
    bus.rd_addr  = '0;
    bus.wr0_en   = 1'b0;
    bus.wr0_addr = '0;
    bus.wr0_data = '0;
    bus.wr1_en   = 1'b0;
    bus.wr1_addr = '0;
    bus.wr1_data = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.clr_req  = 1'b0;
    bus.clr_bank = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic model_zero();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 32; a++) begin
        mm[b][a] = '0;
        mb[b][a] = 1'b0;
      end
  endtask

  task automatic test_reset();
    logic [31:0] e;
    idle();
    reset = 1'b1;
    bus.clr_req  = 1'b1;
    bus.clr_bank = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    e = exp_q.pop_front(); vectors++;
    if (32'(bus.clr_busy) !== e) begin
      miscompares++;
      $display("FAIL rst_clr_busy got %h exp %h", bus.clr_busy, e);
    end
    e = exp_q.pop_front(); vectors++;
    if (32'(bus.clr_done) !== e) begin
      miscompares++;
      $display("FAIL rst_clr_done got %h exp %h", bus.clr_done, e);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    exp_q.push_back(32'd0);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if (32'(bus.clr_busy) !== e) begin
      miscompares++;
      $display("FAIL rst_req_ignored got %h exp %h", bus.clr_busy, e);
    end
    model_zero();
  endtask

  task automatic test_readback(input string tag);
    logic [31:0] e;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 32; a += 2) begin
        next_cycle();
        bus.bank_sel = BW'(b);
        bus.rd_addr  = {AW'(a + 1), AW'(a)};
        exp_q.push_back(mm[b][a]);
        exp_q.push_back(mm[b][a + 1]);
        exp_q.push_back(32'(mb[b][a]));
        exp_q.push_back(32'(mb[b][a + 1]));
        @(negedge clk);
        e = exp_q.pop_front(); vectors++;
        if (bus.rd_data[31:0] !== e) begin
          miscompares++;
          $display("FAIL %s_data b%0d r%0d got %h exp %h",
                   tag, b, a, bus.rd_data[31:0], e);
        end
        e = exp_q.pop_front(); vectors++;
        if (bus.rd_data[63:32] !== e) begin
          miscompares++;
          $display("FAIL %s_data b%0d r%0d got %h exp %h",
                   tag, b, a + 1, bus.rd_data[63:32], e);
        end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.rd_busy[0]) !== e) begin
          miscompares++;
          $display("FAIL %s_busy b%0d r%0d got %h exp %h",
                   tag, b, a, bus.rd_busy[0], e);
        end
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.rd_busy[1]) !== e) begin
          miscompares++;
          $display("FAIL %s_busy b%0d r%0d got %h exp %h",
                   tag, b, a + 1, bus.rd_busy[1], e);
        end
      end
  endtask

  task automatic test_dual_write();
    logic [31:0] e;
    next_cycle();
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd3; bus.wr0_data = 32'h11;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd3; bus.wr1_data = 32'h22;
    bus.rd_addr = {5'd4, 5'd3};
    exp_q.push_back(32'h22);
    mm[0][3] = 32'h22;
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if (bus.rd_data[31:0] !== e) begin
      miscompares++;
      $display("FAIL same_addr_bypass got %h exp %h", bus.rd_data[31:0], e);
    end
    next_cycle();
    bus.rd_addr = {5'd4, 5'd3};
    exp_q.push_back(32'h22);
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if (bus.rd_data[31:0] !== e) begin
      miscompares++;
      $display("FAIL same_addr_stored got %h exp %h", bus.rd_data[31:0], e);
    end
    next_cycle();
    bus.wr0_en = 1'b1; bus.wr0_addr = 5'd10; bus.wr0_data = 32'hA0;
    bus.wr1_en = 1'b1; bus.wr1_addr = 5'd11; bus.wr1_data = 32'hB1;
    bus.rd_addr = {5'd10, 5'd11};
    exp_q.push_back(32'hB1);
    exp_q.push_back(32'hA0);
    mm[0][10] = 32'hA0;
    mm[0][11] = 32'hB1;
    @(negedge clk);
    e = exp_q.pop_front(); vectors++;
    if (bus.rd_data[31:0] !== e) begin
      miscompares++;
      $display("FAIL split_bypass_p0 got %h exp %h", bus.rd_data[31:0], e);
    end
    e = exp_q.pop_front(); vectors++;
    if (bus.rd_data[63:32] !== e) begin
      miscompares++;
      $display("FAIL split_bypass_p1 got %h exp %h", bus.rd_data[63:32], e);
    end
  endtask

  task automatic test_scoreboard();
    logic [31:0] e;
    bit          bz[6] = '{0, 1, 0, 0, 0, 1};
    logic [31:0] dz[6] = '{32'h0, 32'h0, 32'hAB, 32'hAB, 32'h66, 32'h66};
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      bus.rd_addr = (c < 4) ? {5'd5, 5'd5} : {5'd6, 5'd6};
      if (c == 0) begin
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd5;
      end
      if (c == 2) begin
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd5; bus.wr0_data = 32'hAB;
      end
      if (c == 4) begin
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd6;
        bus.wr1_en = 1'b1; bus.wr1_addr = 5'd6; bus.wr1_data = 32'h66;
      end
      exp_q.push_back(32'(bz[c]));
      exp_q.push_back(dz[c]);
      @(negedge clk);
      e = exp_q.pop_front(); vectors++;
      if (32'(bus.rd_busy[0]) !== e) begin
        miscompares++;
        $display("FAIL sb_busy c%0d got %h exp %h", c, bus.rd_busy[0], e);
      end
      e = exp_q.pop_front(); vectors++;
      if (bus.rd_data[31:0] !== e) begin
        miscompares++;
        $display("FAIL sb_data c%0d got %h exp %h", c, bus.rd_data[31:0], e);
      end
    end
    mm[0][5] = 32'hAB;
    mm[0][6] = 32'h66;
    mb[0][6] = 1'b1;
  endtask

  task automatic test_zero_r0();
    logic [31:0] e;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      bus.rd_addr = '0;
      if (c == 0) begin
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd0; bus.wr0_data = 32'hFFFF_FFFF;
      end
      if (c == 2) begin
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
      end
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      @(negedge clk);
      e = exp_q.pop_front(); vectors++;
      if (bus.rd_data[31:0] !== e) begin
        miscompares++;
        $display("FAIL r0_data c%0d got %h exp %h", c, bus.rd_data[31:0], e);
      end
      e = exp_q.pop_front(); vectors++;
      if (32'(bus.rd_busy[0]) !== e) begin
        miscompares++;
        $display("FAIL r0_busy c%0d got %h exp %h", c, bus.rd_busy[0], e);
      end
    end
  endtask

  task automatic fill(input int b, input logic [31:0] base, input bit use1);
    for (int a = 0; a < 32; a++) begin
      next_cycle();
      bus.bank_sel = BW'(b);
      if (use1) begin
        bus.wr1_en = 1'b1; bus.wr1_addr = AW'(a); bus.wr1_data = base + 32'(a);
      end else begin
        bus.wr0_en = 1'b1; bus.wr0_addr = AW'(a); bus.wr0_data = base + 32'(a);
      end
      if (a != 0) begin
        mm[b][a] = base + 32'(a);
        mb[b][a] = 1'b0;
      end
    end
  endtask

  task automatic test_clear();
    logic [31:0] e;
    int nbusy = 0;
    int ndone = 0;
    int done_c = -1;
    fill(1, 32'h1000, 1'b0);
    fill(0, 32'h2000, 1'b1);
    next_cycle();
    bus.bank_sel = 1'b1; bus.rsv_en = 1'b1; bus.rsv_addr = 5'd7;
    next_cycle();
    bus.rsv_en = 1'b1; bus.rsv_addr = 5'd8;
    mb[0][8] = 1'b1;
    next_cycle();
    bus.clr_req = 1'b1; bus.clr_bank = 1'b1;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      if (c == 4) begin
        bus.bank_sel = 1'b1; bus.rd_addr = {5'd1, 5'd31};
        exp_q.push_back(32'h101F);
        exp_q.push_back(32'h0);
      end
      if (c == 5) begin
        bus.bank_sel = 1'b1; bus.rd_addr = {5'd2, 5'd2};
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd2; bus.wr0_data = 32'hDEAD;
        bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
        exp_q.push_back(32'd1);
        exp_q.push_back(32'h0);
      end
      if (c == 6) begin
        bus.rd_addr = {5'd9, 5'd9};
        bus.wr0_en = 1'b1; bus.wr0_addr = 5'd9; bus.wr0_data = 32'h55;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h55);
        mm[0][9] = 32'h55;
      end
      if (c == 7) begin
        bus.clr_req = 1'b1; bus.clr_bank = 1'b0;
      end
      @(negedge clk);
      if (bus.clr_busy) nbusy++;
      if (bus.clr_done) begin
        ndone++;
        done_c = c;
      end
      if (c == 4) begin
        e = exp_q.pop_front(); vectors++;
        if (bus.rd_data[31:0] !== e) begin
          miscompares++;
          $display("FAIL clr_uncleared got %h exp %h", bus.rd_data[31:0], e);
        end
        e = exp_q.pop_front(); vectors++;
        if (bus.rd_data[63:32] !== e) begin
          miscompares++;
          $display("FAIL clr_cleared got %h exp %h", bus.rd_data[63:32], e);
        end
      end
      if (c == 5 || c == 6) begin
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.wr_drop) !== e) begin
          miscompares++;
          $display("FAIL clr_wr_drop c%0d got %h exp %h", c, bus.wr_drop, e);
        end
        e = exp_q.pop_front(); vectors++;
        if (bus.rd_data[31:0] !== e) begin
          miscompares++;
          $display("FAIL clr_rd c%0d got %h exp %h", c, bus.rd_data[31:0], e);
        end
      end
    end
    vectors++;
    if (nbusy !== 32) begin
      miscompares++;
      $display("FAIL clr_busy_cycles got %0d exp 32", nbusy);
    end
    vectors++;
    if (ndone !== 1 || done_c !== 32) begin
      miscompares++;
      $display("FAIL clr_done_pulse got %0d@%0d exp 1@32", ndone, done_c);
    end
    for (int a = 0; a < 32; a++) begin
      mm[1][a] = '0;
      mb[1][a] = 1'b0;
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] e;
    int ndone = 0;
    next_cycle();
    bus.clr_req = 1'b1; bus.clr_bank = 1'b0;
    for (int c = 0; c < 50; c++) begin
      next_cycle();
      if (c == 10) reset = 1'b1;
      if (c == 11) reset = 1'b0;
      if (c == 10) exp_q.push_back(32'd1);
      if (c == 11) exp_q.push_back(32'd0);
      @(negedge clk);
      if (bus.clr_done) ndone++;
      if (c == 10 || c == 11) begin
        e = exp_q.pop_front(); vectors++;
        if (32'(bus.clr_busy) !== e) begin
          miscompares++;
          $display("FAIL abort_busy c%0d got %h exp %h", c, bus.clr_busy, e);
        end
      end
    end
    vectors++;
    if (ndone !== 0) begin
      miscompares++;
      $display("FAIL abort_no_done got %0d exp 0", ndone);
    end
    model_zero();
  endtask

  initial begin
    test_reset();
    test_readback("reset");
    test_dual_write();
    test_scoreboard();
    test_zero_r0();
    test_clear();
    test_readback("clear");
    test_reset_abort();
    test_readback("abort");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
